// File: rtl/ramp_adc_capture.sv
// Single-slope ADC sequencer: ramp reset, 2^RES-step conversion with first-crossing
// capture per comparator channel, then channel-by-channel readout over valid/ready.
//
// state    | meaning
// IDLE     | waiting for enable, ramp parked at 0
// RAMP_RST | analog ramp held in reset, capture registers cleared
// CONVERT  | ramp counting 0..2^RES-1, first flag crossing latched per channel
// READOUT  | streaming one word per channel, out_ch 0..N_CH-1
// DONE     | one-cycle frame_done, then restart or return to IDLE
module ramp_adc_capture #(
  parameter int N_CH       = 128,
  parameter int RES        = 8,
  parameter int RST_CYCLES = 4,
  parameter int CHW        = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] flag,
  output logic            ramp_rst,
  output logic [RES-1:0]  ramp_code,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CHW-1:0]  out_ch,
  output logic [RES-1:0]  out_code,
  output logic            out_hit,
  output logic            out_last,
  output logic            frame_done
);

  localparam int TW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RES-1:0] CODE_MAX = '1;
  localparam logic [CHW-1:0] CH_LAST  = CHW'(N_CH - 1);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAMP_RST = 3'd1,
    CONVERT  = 3'd2,
    READOUT  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [TW-1:0]   tmr;
  logic [N_CH-1:0] flag_q;
  logic [N_CH-1:0] hit;
  logic [RES-1:0]  code [N_CH];
  logic            accept;
  logic            entering_rst;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ramp_rst   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable) next_state = RAMP_RST;
      end
      RAMP_RST: begin
        ramp_rst = 1'b1;
        if (tmr == '0) next_state = CONVERT;
      end
      CONVERT: begin
        if (ramp_code == CODE_MAX) next_state = READOUT;
      end
      READOUT: begin
        out_valid = 1'b1;
        if (out_ready && (out_ch == CH_LAST)) next_state = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = enable ? RAMP_RST : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept       = out_valid & out_ready;
  assign entering_rst = (next_state == RAMP_RST) && (state != RAMP_RST);

  // Readout fields are forced to zero outside READOUT so idle outputs are clean.
  assign out_code = out_valid ? code[out_ch] : '0;
  assign out_hit  = out_valid ? hit[out_ch]  : 1'b0;
  assign out_last = out_valid && (out_ch == CH_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q    <= '0;
      hit       <= '0;
      ramp_code <= '0;
      tmr       <= '0;
      out_ch    <= '0;
      for (int i = 0; i < N_CH; i++) code[i] <= '0;
    end else begin
      flag_q <= flag;
      if (entering_rst) begin
        hit       <= '0;
        ramp_code <= '0;
        tmr       <= TMR_LOAD;
        out_ch    <= '0;
        for (int i = 0; i < N_CH; i++) code[i] <= CODE_MAX;
      end else begin
        case (state)
          RAMP_RST: begin
            if (tmr != '0) tmr <= tmr - 1'b1;
          end
          CONVERT: begin
            // First crossing wins; later flag activity on a hit channel is ignored.
            for (int i = 0; i < N_CH; i++) begin
              if (flag_q[i] && !hit[i]) begin
                code[i] <= ramp_code;
                hit[i]  <= 1'b1;
              end
            end
            if (ramp_code != CODE_MAX) ramp_code <= ramp_code + 1'b1;
          end
          READOUT: begin
            if (accept) out_ch <= (out_ch == CH_LAST) ? '0 : out_ch + 1'b1;
          end
          DONE: begin
            if (next_state == IDLE) ramp_code <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ramp_adc_capture.sv
// Randomised scoreboard bench for ramp_adc_capture: flag waveforms are tables indexed
// by ramp step, and the expected code per channel is the first step its flag is high.
module tb_ramp_adc_capture;

  localparam int N_CH = 4;
  localparam int RES = 4;
  localparam int RST_CYCLES = 2;
  localparam int CHW = 2;
  localparam int NK = 1 << RES;

  typedef logic [N_CH-1:0][NK-1:0] masks_t;
  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [RES-1:0] code;
    logic           hit;
    logic           last;
  } word_t;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [N_CH-1:0] flag;
  logic            ramp_rst;
  logic [RES-1:0]  ramp_code;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [CHW-1:0]  out_ch;
  logic [RES-1:0]  out_code;
  logic            out_hit;
  logic            out_last;
  logic            frame_done;

  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;
  time   frame_start_t = 0;
  word_t exp_q[$];

  ramp_adc_capture #(.N_CH(N_CH), .RES(RES), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flag(flag),
    .ramp_rst(ramp_rst), .ramp_code(ramp_code), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_code(out_code), .out_hit(out_hit), .out_last(out_last),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: code is the first ramp step at which the flag is seen high.
  function automatic word_t model(input int ch, input logic [NK-1:0] mk);
    word_t w;
    w.ch   = CHW'(ch);
    w.code = '1;
    w.hit  = 1'b0;
    for (int k = NK - 1; k >= 0; k--) begin
      if (mk[k]) begin
        w.code = RES'(k);
        w.hit  = 1'b1;
      end
    end
    w.last = (ch == N_CH - 1);
    return w;
  endfunction

  function automatic logic [NK-1:0] rand_mask();
    logic [NK-1:0] f;
    f = '1;
    case ($urandom_range(0, 3))
      0: return '0;
      1: return NK'($urandom);
      2: return f << $urandom_range(0, NK - 1);
      default: return NK'($urandom & $urandom & $urandom);
    endcase
  endfunction

  function automatic masks_t rand_masks();
    masks_t m;
    for (int i = 0; i < N_CH; i++) m[i] = rand_mask();
    return m;
  endfunction

  task automatic drive_col(input masks_t m, input int k);
    for (int i = 0; i < N_CH; i++) flag[i] = m[i][k];
  endtask

  // Tracks one frame from the first ramp_rst cycle to the last ramp step.
  task automatic run_frame(input masks_t m, input int drop_at, input int abort_at);
    int n;
    n = 0;
    while (!ramp_rst && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ramp_rst_start", 32'(ramp_rst), 32'd1);
    if (!ramp_rst) return;
    frame_start_t = $time;
    check("rst_code0", 32'(ramp_code), 32'd0);
    for (int r = 1; r < RST_CYCLES; r++) begin
      @(negedge clk);
      check("rst_hold", 32'({ramp_rst, ramp_code}), 32'({1'b1, 4'd0}));
    end
    drive_col(m, 0);
    for (int k = 0; k < NK; k++) begin
      @(negedge clk);
      check("ramp_step", 32'({ramp_rst, busy, ramp_code}), 32'({1'b0, 1'b1, 4'(k)}));
      if (k == abort_at) begin
        reset  = 1'b1;
        enable = 1'b0;
        return;
      end
      if (k == drop_at) enable = 1'b0;
      if (k < NK - 1) drive_col(m, k + 1);
      else flag = N_CH'($urandom);
    end
    for (int i = 0; i < N_CH; i++) exp_q.push_back(model(i, m[i]));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    check("idle_reached", 32'({busy, ramp_code, ramp_rst}), 32'd0);
  endtask

  task automatic check_reset_state(input string name);
    @(posedge clk);
    #1;
    check(name, 32'({ramp_rst, ramp_code, busy, out_valid, out_ch, out_code, out_hit,
                     out_last, frame_done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops an expected word on every accepted handshake.
  initial begin
    word_t w;
    logic [7:0] cur;
    logic [7:0] prev;
    logic stalled;
    logic exp_done;
    stalled = 1'b0;
    exp_done = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        stalled = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (exp_done) begin
          check("frame_done_pulse", 32'(frame_done), 32'd1);
          exp_done = 1'b0;
        end else if (frame_done) begin
          check("frame_done_unexpected", 32'(frame_done), 32'd0);
        end
        cur = {out_ch, out_code, out_hit, out_last};
        if (stalled) check("stall_hold", 32'({out_valid, cur}), 32'({1'b1, prev}));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("word_unexpected", 32'(cur), 32'hFFFF_FFFF);
          end else begin
            w = exp_q.pop_front();
            check("word", 32'(cur), 32'(w));
            if (w.last) exp_done = 1'b1;
          end
          stalled = 1'b0;
        end else if (out_valid) begin
          stalled = 1'b1;
          prev = cur;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    masks_t m;
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    flag   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_outputs", 32'({ramp_rst, ramp_code, busy, out_valid, out_ch, out_code,
                                 out_hit, out_last, frame_done}), 32'd0);
    end

    // Directed frame, enable dropped mid-conversion: one frame then IDLE.
    ready_mode = 0;
    m[0] = 16'hFFF8;
    m[1] = 16'hFE00;
    m[2] = 16'hFFFF;
    m[3] = 16'h0000;
    enable = 1'b1;
    run_frame(m, 7, -1);
    n = 0;
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_len", 32'(int'(($time - frame_start_t) / 10) + 1), 32'd23);
    @(negedge clk);
    check("after_stop", 32'({busy, ramp_code, ramp_rst}), 32'd0);
    repeat (5) @(negedge clk);
    check("stays_idle", 32'(busy), 32'd0);

    // Backpressure with glitching flag on ch1, back-to-back frames.
    ready_mode = 1;
    m = rand_masks();
    m[1] = 16'hF020;
    enable = 1'b1;
    run_frame(m, -1, -1);
    run_frame(rand_masks(), -1, -1);
    run_frame(rand_masks(), 7, -1);
    wait_idle();

    ready_mode = 2;
    enable = 1'b1;
    for (int f = 0; f < 4; f++) run_frame(rand_masks(), (f == 3) ? 7 : -1, -1);
    wait_idle();

    // Reset during conversion, then a fresh frame.
    ready_mode = 0;
    enable = 1'b1;
    run_frame(16'hFFFF, -1, 6);
    check_reset_state("reset_mid_convert");
    m = rand_masks();
    m[3] = '0;
    enable = 1'b1;
    run_frame(m, 0, -1);
    wait_idle();

    // Reset during readout at channel 2.
    ready_mode = 2;
    enable = 1'b1;
    run_frame(rand_masks(), 3, -1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ch == 2) && n < 100);
    check("reach_ch2", 32'({out_valid, out_ch}), 32'({1'b1, 2'd2}));
    reset = 1'b1;
    check_reset_state("reset_mid_readout");
    ready_mode = 1;
    m = rand_masks();
    m[0] = '0;
    enable = 1'b1;
    run_frame(m, 0, -1);
    wait_idle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramp_adc_capture.md
Name: ramp_adc_capture

Overview:
- Parametrised single-slope (ramp) ADC conversion and readout engine for the comparator-flag array.
- Sequences a ramp-reset phase and a RES-bit counting phase, driving the ramp DAC code.
- Latches a per-channel code when each comparator flag first asserts.
- Streams the frame out channel by channel over a valid/ready handshake, then repeats while enabled. Sits between the central controller (which drives enable) and the readout/SPI path.

Parameters:
- N_CH, 128, number of comparator channels (flag width).
- RES, 8, conversion resolution in bits; CONVERT phase lasts 2^RES cycles.
- RST_CYCLES, 4, cycles ramp_rst is held high before each conversion (>=1).
- CHW, $clog2(N_CH), channel index width (derived; not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request from controller; sampled in IDLE and at end of frame
- flag  in  N_CH  comparator outputs, 1 = ramp has crossed the channel input
- ramp_rst  out  1  ramp/integrator reset to analog
- ramp_code  out  RES  current ramp counter value (DAC code)
- busy  out  1  high in any state other than IDLE
- out_valid  out  1  readout word valid
- out_ready  in  1  downstream accepts word
- out_ch  out  CHW  channel index of current word
- out_code  out  RES  captured code
- out_hit  out  1  1 = flag seen this frame; 0 = no crossing (code saturated)
- out_last  out  1  high with the word for channel N_CH-1
- frame_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset: state=IDLE; ramp_rst=0, ramp_code=0, busy=0, out_valid=0, out_ch=0, out_code=0, out_hit=0, out_last=0, frame_done=0.
- Reset clears all code/hit registers and flag_q. Reset wins over every other event, including mid-conversion and mid-readout; the partial frame is discarded with no frame_done.
- Flag input: registered once into flag_q every cycle (one-cycle capture latency). No further synchronisation inside the block.
- FSM states: IDLE, RAMP_RST, CONVERT, READOUT, DONE.
  - IDLE: enable=1 -> RAMP_RST.
  - RAMP_RST:
    - ramp_rst=1 for exactly RST_CYCLES cycles, then -> CONVERT.
    - On entry, all hit[i]=0, code[i]=all-ones, ramp_code=0.
    - Flags are ignored during this phase.
  - CONVERT:
    - ramp_code=k runs 0,1,...,2^RES-1, one value per cycle.
    - In the cycle showing k: for each i with flag_q[i]=1 and hit[i]=0, code[i]<=k and hit[i]<=1. All qualifying channels capture in parallel.
    - Later flag activity on a hit channel, including deassert/reassert, is ignored (first crossing wins).
    - A flag already high at CONVERT start captures code 0.
    - After the k=2^RES-1 cycle -> READOUT; ramp_code holds 2^RES-1.
  - READOUT:
    - out_valid=1; out_ch starts at 0; out_code=code[out_ch], out_hit=hit[out_ch], out_last=(out_ch==N_CH-1).
    - Outputs are stable while out_valid & !out_ready.
    - On out_valid & out_ready: out_ch increments. If out_last is accepted -> DONE, out_valid=0.
    - Unhit channels read code = 2^RES-1 with out_hit=0.
  - DONE:
    - frame_done=1 for one cycle.
    - Next state: enable=1 -> RAMP_RST; else -> IDLE, with ramp_code returning to 0.
- enable deasserted mid-frame does not abort: the frame completes and is fully streamed.
- busy = (state != IDLE).
- Frame length with out_ready tied high: RST_CYCLES + 2^RES + N_CH + 1 cycles.

Test Plan:
- Bench params N_CH=4, RES=4, RST_CYCLES=2 throughout.
- Reset/idle: hold enable=0 after reset → all outputs 0, busy=0, state stays IDLE for 20 cycles.
- Basic frame:
  - Stimulus: raise flag[0] just before the edge entering ramp_code=3, flag[1] before ramp_code=9, flag[2] before ramp_code=0, flag[3] never; out_ready=1.
  - Response: words (ch,code,hit) = (0,3,1), (1,9,1), (2,0,1), (3,15,0); out_last only on ch3; frame_done one cycle after; total 2+16+4+1=23 cycles.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,... during READOUT.
  - Response: out_ch/out_code/out_hit stable while stalled; each channel delivered exactly once, in order 0..3.
- Flag glitch:
  - Stimulus: flag[1] high for ramp_code=5 only, then high again from ramp_code=12.
  - Response: ch1 code=5, hit=1.
- Continuous vs stop:
  - Stimulus: enable held → back-to-back frames with ramp_rst high 2 cycles between them.
  - Stimulus: enable dropped at ramp_code=7 → current frame completes, then IDLE, busy=0.
- Reset mid-operation:
  - Stimulus: assert reset at ramp_code=6, and separately at out_ch=2 with out_valid=1.
  - Response: next cycle all outputs at reset values, no frame_done; a following frame reports fresh codes (no stale hits).
